// File: rtl/pivot_rom_arbiter_if.sv
// pivot_rom_arbiter_if
//   Bundles the two client toggle-handshake ports, the SDRAM ROM toggle
//   port, the tag-invalidate strobe and the busy flag.
//   slave  : arbiter view (clients/SDRAM/inval in, acks/data/sdr_req out)
//   master : environment view (the side that issues client requests and
//            answers the SDRAM channel)
interface pivot_rom_arbiter_if;
  logic [26:0] c0_addr;
  logic        c0_req;
  logic        c0_ack;
  logic [15:0] c0_data;
  logic [26:0] c1_addr;
  logic        c1_req;
  logic        c1_ack;
  logic [15:0] c1_data;
  logic [26:0] sdr_addr;
  logic        sdr_req;
  logic        sdr_ack;
  logic [15:0] sdr_data;
  logic        inval;
  logic        busy;

  modport slave (
    input  c0_addr, c0_req, c1_addr, c1_req, sdr_ack, sdr_data, inval,
    output c0_ack, c0_data, c1_ack, c1_data, sdr_addr, sdr_req, busy
  );

  modport master (
    output c0_addr, c0_req, c1_addr, c1_req, sdr_ack, sdr_data, inval,
    input  c0_ack, c0_data, c1_ack, c1_data, sdr_addr, sdr_req, busy
  );
endinterface

// File: rtl/pivot_rom_arbiter.sv
// pivot_rom_arbiter
//   Shares one toggle-handshake SDRAM ROM channel between two toggle-handshake
//   clients (0 = pivot/ROZ pixel fetch, 1 = secondary fetch). Each client keeps
//   a one-word hit register so repeated reads of the same 16-bit word are
//   answered locally in one clock. Client 0 has fixed priority; client 1 is
//   forced after STARVE_MAX consecutive client-0 grants while it waits.
// Ports
//   clk, reset : clock, asynchronous active-high reset
//   bus        : pivot_rom_arbiter_if.slave (client ports, SDRAM port, inval, busy)
// Parameters
//   STARVE_MAX : client-0 grants tolerated while client 1 pends
//   HIT_EN     : 1 enables the per-client hit registers

// Per-client ack/data/tag state. The data register doubles as the hold word:
// it only ever changes on a fill, so it always carries the last fetched word.
module pivot_rom_client #(
  parameter int HIT_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inval,
  input  logic        req,
  input  logic [25:0] addr_w,
  input  logic        hit_take,
  input  logic        fill_take,
  input  logic        fill_keep,
  input  logic [25:0] fill_tag,
  input  logic [15:0] fill_data,
  output logic        ack,
  output logic [15:0] data,
  output logic        pend,
  output logic        hit
);
  logic [25:0] tag;
  logic        tag_vld;

  assign pend = req ^ ack;
  // inval beats a hit in the same cycle; the request then goes to SDRAM
  assign hit  = (HIT_EN != 0) && tag_vld && (tag == addr_w) && !inval;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack     <= 1'b0;
      data    <= '0;
      tag     <= '0;
      tag_vld <= 1'b0;
    end else begin
      if (hit_take) begin
        ack <= req;
      end else if (fill_take) begin
        ack  <= req;
        data <= fill_data;
        tag  <= fill_tag;
      end
      if (fill_take)  tag_vld <= fill_keep & ~inval;
      else if (inval) tag_vld <= 1'b0;
    end
  end
endmodule

module pivot_rom_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int HIT_EN     = 1
) (
  input logic               clk,
  input logic               reset,
  pivot_rom_arbiter_if.slave bus
);
  localparam int NCLI = 2;
  localparam int SW   = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {SYNC, IDLE, WAIT} state_t;

  state_t                     state;
  logic [NCLI-1:0]            req, ack, pend, hit, hit_take, fill_take;
  logic [NCLI-1:0][25:0]      addr_w;
  logic [NCLI-1:0][15:0]      data;
  logic [SW-1:0]              starve;
  logic                       gnt, gnt_q, any_pend, inval_seen, sdr_done;
  logic                       sdr_req_q, busy_q;
  logic [26:0]                sdr_addr_q;
  logic                       unused_addr_lsb;

  assign req             = {bus.c1_req, bus.c0_req};
  assign addr_w          = {bus.c1_addr[26:1], bus.c0_addr[26:1]};
  assign unused_addr_lsb = bus.c0_addr[0] ^ bus.c1_addr[0];

  assign bus.c0_ack   = ack[0];
  assign bus.c1_ack   = ack[1];
  assign bus.c0_data  = data[0];
  assign bus.c1_data  = data[1];
  assign bus.sdr_addr = sdr_addr_q;
  assign bus.sdr_req  = sdr_req_q;
  assign bus.busy     = busy_q;

  assign sdr_done = (bus.sdr_ack == sdr_req_q);
  assign any_pend = |pend;

  // Grant: forced client 1 when starved, else client 0 if pending, else 1.
  always_comb begin
    if (pend[1] && starve == SW'(STARVE_MAX)) gnt = 1'b1;
    else                                       gnt = !pend[0];
  end

  always_comb begin
    hit_take  = '0;
    fill_take = '0;
    if (state == IDLE && any_pend && hit[gnt]) hit_take[gnt]   = 1'b1;
    if (state == WAIT && sdr_done)             fill_take[gnt_q] = 1'b1;
  end

  for (genvar i = 0; i < NCLI; i++) begin : g_cli
    pivot_rom_client #(.HIT_EN(HIT_EN)) u_cli (
      .clk       (clk),
      .reset     (reset),
      .inval     (bus.inval),
      .req       (req[i]),
      .addr_w    (addr_w[i]),
      .hit_take  (hit_take[i]),
      .fill_take (fill_take[i]),
      .fill_keep (!inval_seen),
      .fill_tag  (sdr_addr_q[26:1]),
      .fill_data (bus.sdr_data),
      .ack       (ack[i]),
      .data      (data[i]),
      .pend      (pend[i]),
      .hit       (hit[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SYNC;
      busy_q     <= 1'b1;
      sdr_req_q  <= 1'b0;
      sdr_addr_q <= '0;
      gnt_q      <= 1'b0;
      starve     <= '0;
      inval_seen <= 1'b0;
    end else begin
      case (state)
        // An access may have been in flight when reset hit; let it drain
        // without acking any client.
        SYNC: if (sdr_done) begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        IDLE: begin
          if (!pend[1] || gnt)                starve <= '0;
          else if (starve != SW'(STARVE_MAX)) starve <= starve + 1'b1;
          if (any_pend && !hit[gnt]) begin
            sdr_addr_q <= {addr_w[gnt], 1'b0};
            sdr_req_q  <= ~sdr_req_q;
            gnt_q      <= gnt;
            inval_seen <= bus.inval;
            state      <= WAIT;
            busy_q     <= 1'b1;
          end
        end
        WAIT: begin
          // A fill that overlapped an invalidate may be stale: deliver it
          // but do not trust it as a tag.
          inval_seen <= inval_seen | bus.inval;
          if (sdr_done) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= SYNC;
          busy_q <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pivot_rom_arbiter.sv
module tb_pivot_rom_arbiter;
  localparam int SMAX  = 4;
  localparam int HITEN = 1;
  localparam int SDLAT = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pivot_rom_arbiter_if bus();

  pivot_rom_arbiter #(.STARVE_MAX(SMAX), .HIT_EN(HITEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  function automatic logic [15:0] mem(input logic [26:0] a);
    if (a == 27'h100) return 16'hA5C3;
    return a[16:1] ^ 16'h5A5A;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  // Inputs are only changed just after a rising edge, so the values seen at
  // a falling edge are the ones the next rising edge will sample.
  logic        p_rst = 1'b1, p_inval = 1'b0, p_sack = 1'b0;
  logic [15:0] p_sdata = '0;
  logic        p_req  [2];
  logic [26:0] p_addr [2];

  bit          m_sync, m_out, m_owin, m_sreq, pn0, pn1;
  int          m_og, m_starve, g;
  logic [25:0] m_oaddr;
  logic [26:0] m_saddr;
  logic        m_ack  [2];
  logic [15:0] m_data [2];   // last fill per client, also its hold word
  logic [25:0] m_tag  [2];
  bit          m_tv   [2];

  always @(negedge clk) begin
    cyc++;
    if (reset || p_rst) begin
      m_sync = 1; m_out = 0; m_owin = 0; m_sreq = 0; m_saddr = '0;
      m_og = 0; m_oaddr = '0; m_starve = 0;
      for (int i = 0; i < 2; i++) begin
        m_ack[i] = 1'b0; m_data[i] = '0; m_tag[i] = '0; m_tv[i] = 0;
      end
    end else begin
      if (m_sync) begin
        if (p_sack == m_sreq) m_sync = 0;
      end else if (m_out) begin
        if (p_sack == m_sreq) begin
          m_ack[m_og]  = p_req[m_og];
          m_data[m_og] = p_sdata;
          m_tag[m_og]  = m_oaddr;
          m_tv[m_og]   = !(m_owin || p_inval);
          m_out        = 0;
        end else begin
          m_owin = m_owin || p_inval;
        end
      end else begin
        pn0 = (p_req[0] != m_ack[0]);
        pn1 = (p_req[1] != m_ack[1]);
        if (pn0 || pn1) begin
          g = (pn1 && m_starve == SMAX) ? 1 : (pn0 ? 0 : 1);
          if (!pn1 || g == 1)      m_starve = 0;
          else if (m_starve < SMAX) m_starve = m_starve + 1;
          if (HITEN != 0 && m_tv[g] && m_tag[g] == p_addr[g][26:1] && !p_inval) begin
            m_ack[g] = p_req[g];
          end else begin
            m_sreq  = !m_sreq;
            m_saddr = {p_addr[g][26:1], 1'b0};
            m_out   = 1;
            m_og    = g;
            m_oaddr = p_addr[g][26:1];
            m_owin  = p_inval;
          end
        end else begin
          m_starve = 0;
        end
      end
      if (p_inval) begin m_tv[0] = 0; m_tv[1] = 0; end
    end

    n_tests++;
    if (bus.c0_ack !== m_ack[0] || bus.c1_ack !== m_ack[1] ||
        bus.c0_data !== m_data[0] || bus.c1_data !== m_data[1] ||
        bus.sdr_req !== m_sreq || bus.sdr_addr !== m_saddr ||
        bus.busy !== (m_sync || m_out)) begin
      n_fail++;
      $display("FAIL cycle_check cyc=%0d got ack=%b%b d0=%h d1=%h sreq=%b saddr=%h busy=%b want ack=%b%b d0=%h d1=%h sreq=%b saddr=%h busy=%b",
               cyc, bus.c1_ack, bus.c0_ack, bus.c0_data, bus.c1_data, bus.sdr_req, bus.sdr_addr, bus.busy,
               m_ack[1], m_ack[0], m_data[0], m_data[1], m_sreq, m_saddr, (m_sync || m_out));
    end

    p_rst    = reset;
    p_inval  = bus.inval;
    p_sack   = bus.sdr_ack;
    p_sdata  = bus.sdr_data;
    p_req[0] = bus.c0_req;  p_addr[0] = bus.c0_addr;
    p_req[1] = bus.c1_req;  p_addr[1] = bus.c1_addr;
  end

  // ---------------- SDRAM responder ----------------
  bit          sd_en = 0, sd_act = 0;
  int          sd_cnt = 0;
  logic        sd_tgt = 1'b0;
  logic [26:0] sd_a = '0;

  initial forever begin
    tick();
    if (sd_en) begin
      if (sd_act) begin
        sd_cnt--;
        if (sd_cnt == 0) begin
          bus.sdr_data = mem(sd_a);
          bus.sdr_ack  = sd_tgt;
          sd_act       = 0;
        end
      end else if (bus.sdr_req != bus.sdr_ack) begin
        sd_act = 1; sd_tgt = bus.sdr_req; sd_a = bus.sdr_addr; sd_cnt = SDLAT;
      end
    end
  end

  // ---------------- client driver ----------------
  task automatic issue(input int c, input logic [26:0] a);
    if (c == 0) begin bus.c0_addr = a; bus.c0_req = !bus.c0_req; end
    else        begin bus.c1_addr = a; bus.c1_req = !bus.c1_req; end
  endtask

  function automatic logic pend_of(input int c);
    return (c == 0) ? (bus.c0_req ^ bus.c0_ack) : (bus.c1_req ^ bus.c1_ack);
  endfunction

  task automatic wait_ack(input int c, input string nm, output int n);
    n = 0;
    while (pend_of(c) && n < 100) begin tick(); n++; end
    chk({nm, "_ack_timeout"}, 32'(pend_of(c)), 0);
  endtask

  initial begin
    int n, k, n0;
    logic r0;
    bus.c0_addr = '0; bus.c0_req = 1'b0;
    bus.c1_addr = '0; bus.c1_req = 1'b0;
    bus.sdr_ack = 1'b1; bus.sdr_data = '0; bus.inval = 1'b0;

    // 1: reset with an SDRAM access apparently in flight
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_busy",    32'(bus.busy), 1);
    chk("rst_c0_ack",  32'(bus.c0_ack), 0);
    chk("rst_c1_ack",  32'(bus.c1_ack), 0);
    chk("rst_sdr_req", 32'(bus.sdr_req), 0);
    chk("rst_c0_data", 32'(bus.c0_data), 0);
    reset = 1'b0;
    repeat (4) tick();
    chk("sync_hold_busy", 32'(bus.busy), 1);
    bus.sdr_ack = 1'b0;
    tick();
    chk("sync_exit_busy", 32'(bus.busy), 0);
    sd_en = 1;

    // 2: first miss
    r0 = bus.sdr_req;
    issue(0, 27'h100);
    wait_ack(0, "t2", n);
    chk("t2_latency", 32'(n), 2 + SDLAT);
    chk("t2_data",    32'(bus.c0_data), 32'hA5C3);
    chk("t2_saddr",   32'(bus.sdr_addr), 32'h100);
    chk("t2_sreq",    32'(bus.sdr_req), 32'(!r0));

    // 3: same word, odd byte -> hit
    r0 = bus.sdr_req;
    issue(0, 27'h101);
    wait_ack(0, "t3", n);
    chk("t3_latency", 32'(n), 1);
    chk("t3_data",    32'(bus.c0_data), 32'hA5C3);
    chk("t3_sreq",    32'(bus.sdr_req), 32'(r0));

    // 4: starvation guard
    n0 = 0; k = 0;
    issue(1, 27'h2000);
    issue(0, 27'h1000);
    while (pend_of(1) && k < 300) begin
      tick(); k++;
      if (!pend_of(0) && pend_of(1)) begin
        n0++;
        issue(0, 27'h1000 + 27'(4 * n0));
      end
    end
    chk("t4_c1_timeout",   32'(pend_of(1)), 0);
    chk("t4_c0_before_c1", 32'(n0), SMAX);
    chk("t4_c1_data",      32'(bus.c1_data), 32'(mem(27'h2000)));
    issue(1, 27'h2004);
    wait_ack(0, "t4b", n);
    chk("t4_starve_reset", 32'(pend_of(1)), 1);
    chk("t4_c0_last",      32'(bus.c0_data), 32'(mem(27'h1010)));
    wait_ack(1, "t4c", n);
    chk("t4_c1_data2",     32'(bus.c1_data), 32'(mem(27'h2004)));

    // 5: inval during WAIT
    issue(0, 27'h200);
    tick(); tick();
    bus.inval = 1'b1;
    tick();
    bus.inval = 1'b0;
    wait_ack(0, "t5a", n);
    chk("t5_data", 32'(bus.c0_data), 32'(mem(27'h200)));
    r0 = bus.sdr_req;
    issue(0, 27'h200);
    wait_ack(0, "t5b", n);
    chk("t5_refetch_sreq", 32'(bus.sdr_req), 32'(!r0));
    chk("t5_refetch_lat",  32'(n), 2 + SDLAT);
    issue(0, 27'h201);
    wait_ack(0, "t5c", n);
    chk("t5_hit_lat", 32'(n), 1);
    // client 1 on the same word must miss and leave client 0's tag alone
    r0 = bus.sdr_req;
    issue(1, 27'h200);
    wait_ack(1, "t5d", n);
    chk("t5_c1_miss", 32'(bus.sdr_req), 32'(!r0));
    issue(0, 27'h201);
    wait_ack(0, "t5e", n);
    chk("t5_c0_still_hit", 32'(n), 1);
    // inval coincident with a would-be hit forces a miss
    r0 = bus.sdr_req;
    bus.inval = 1'b1;
    issue(0, 27'h200);
    tick();
    bus.inval = 1'b0;
    wait_ack(0, "t5f", n);
    chk("t5_inval_prio", 32'(bus.sdr_req), 32'(!r0));

    // 6: reset during WAIT; the next toggle must go 1->0 so the late ack
    // shows up as a mismatch that SYNC has to absorb
    if (bus.sdr_req == 1'b0) begin
      issue(0, 27'h400);
      wait_ack(0, "t6pre", n);
    end
    issue(0, 27'h300);
    tick(); tick();
    reset = 1'b1;
    bus.c0_req = 1'b0; bus.c1_req = 1'b0;
    tick();
    chk("t6_rst_c0_ack", 32'(bus.c0_ack), 0);
    chk("t6_rst_busy",   32'(bus.busy), 1);
    reset = 1'b0;
    k = 0;
    while (bus.busy && k < 50) begin tick(); k++; end
    chk("t6_sync_timeout", 32'(bus.busy), 0);
    chk("t6_sync_cycles",  32'(k), 4);
    chk("t6_c0_ack", 32'(bus.c0_ack), 0);
    chk("t6_c1_ack", 32'(bus.c1_ack), 0);
    issue(1, 27'h500);
    wait_ack(1, "t6", n);
    chk("t6_c1_lat",  32'(n), 2 + SDLAT);
    chk("t6_c1_data", 32'(bus.c1_data), 32'(mem(27'h500)));

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
